lut_index_finder: RTL and testbench
===================================

# lut_index_finder

Sequential reverse-lookup engine: given a 10-bit value, it returns the 5-bit index of the first table entry holding that value. It is the decode direction of the core's 5-bit → 10-bit constant/tap/branch-target table. Program 3 uses it to recover which tap pattern or constant produced an observed 10-bit word. The block holds its own writable 32-entry copy of the table, loaded through a write port, and scans it one entry per cycle under a Start/Done handshake.

## Interface
- DEPTH, default 32: number of table entries
- AW, default 5: index width; DEPTH = 2**AW
- DW, default 10: entry/key width
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low reset (Reset = 0 resets)
- WrEn  input  1  write strobe for table load
- WrAddr  input  AW  entry to write
- WrData  input  DW  value to write; the write also sets that entry's valid bit
- Start  input  1  begin a search; sampled only in IDLE
- Key  input  DW  value to search for; latched on the accepted Start edge
- Busy  output  1  high while in SEARCH
- Done  output  1  one-cycle pulse when the result becomes valid
- Hit  output  1  1 = a valid entry matched Key
- Index  output  AW  lowest matching index; 0 on miss

## Operation
- Storage: DEPTH × DW data plus DEPTH valid bits. After reset all valid bits are 0, unless the preload described under Configuration is compiled in.
- FSM has three states: IDLE, SEARCH, DONE.
  - IDLE: if Start = 1, latch Key into KeyQ, set Ptr = 0, clear Hit/Index, and go to SEARCH.
  - SEARCH: compare entry[Ptr] with KeyQ; a match requires valid[Ptr] = 1.
    - On a match: Hit ← 1, Index ← Ptr, go to DONE.
    - On no match with Ptr = DEPTH-1: Hit ← 0, Index ← 0, go to DONE.
    - Otherwise: Ptr ← Ptr+1.
  - DONE: Done = 1 for exactly this cycle; go to IDLE unconditionally. A Start asserted during DONE is ignored.
- Priority: with duplicate values, the lowest index wins because the scan is ascending.
- Writes are accepted in IDLE and DONE only; WrEn during SEARCH is dropped with no side effect. The table is therefore stable for the whole scan.
- Write and Start in the same IDLE cycle: the write commits on that edge, and the search sees the new value.
- Start during SEARCH is ignored; Key changes after the accepted edge are ignored.
- Hit and Index hold their values from Done until the next accepted Start.
- Ptr is AW bits wide. The terminal compare uses Ptr = DEPTH-1, so Ptr never wraps.

## Timing
- Reset values: Busy = 0, Done = 0, Hit = 0, Index = 0, state IDLE, Ptr = 0, KeyQ = 0.
- Reset asserted mid-search aborts immediately. No Done is produced, and the table returns to its reset contents.
- Cycle 0 is the cycle in which Start is sampled high in IDLE.
  - Busy is high in cycles 1 through i+1 for a hit at index i; Done is high in cycle i+2.
  - On a miss, Busy is high in cycles 1 through DEPTH, and Done is high in cycle DEPTH+1 (cycle 33 with defaults).
- Worst-case back-to-back throughput is one search per DEPTH+2 cycles. The earliest new Start is the cycle after Done.
- Outputs are registered; there is no combinational path from inputs to outputs.
- A write issued in cycle n is visible to a search whose Start is in cycle n or later.

## Configuration
- Macro: LUT_FIND_PRELOAD_EN
- Defined: reset loads entries 0–8 with the tap patterns and sets their valid bits. Entries 9–31 are invalid.
  - Entries 0–4: 0x060, 0x048, 0x078, 0x072, 0x06A.
  - Entries 5–8: 0x069, 0x05C, 0x07E, 0x07B.
- Not defined: reset clears all valid bits; data contents are don't-care. The table must be loaded via WrEn before use.
- Run-time behaviour after reset is identical in both builds.

## Test plan
- Preload build, Key = 0x072 → Hit = 1, Index = 3, Done in cycle 5, Busy high in cycles 1–4.
- No-preload build, load entry 12 = 0x040, Key = 0x040 → Hit = 1, Index = 12, Done in cycle 14. Key = 0x041 → Hit = 0, Index = 0, Done in cycle 33.
- Write 0x020 to entries 20 and 7, Key = 0x020 → Index = 7. Then write entry 7 = 0x3FF during SEARCH → write is dropped, and the next search for 0x020 still returns 7.
- Same-cycle WrEn (entry 0 = 0x155) and Start (Key = 0x155) in IDLE → Hit = 1, Index = 0, Done in cycle 2.
- Drop Reset low in cycle 10 of a miss search → Busy/Done/Hit/Index = 0 immediately, no Done pulse. Preload build: Key = 0x07B afterwards → Index = 8.
- Start held high continuously → searches run back-to-back, with a new search accepted in the cycle after each Done. Start pulses in SEARCH/DONE have no effect.

Source files
------------

// File: rtl/lut_index_finder_if.sv
// Table-load and search handshake bundle for lut_index_finder.
// master drives writes/start/key; slave (the finder) drives busy/done/hit/index.
interface lut_index_finder_if #(
  parameter int AW = 5,
  parameter int DW = 10
);
  logic          wren;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic          start;
  logic [DW-1:0] key;
  logic          busy;
  logic          done;
  logic          hit;
  logic [AW-1:0] index;

  modport master (
    output wren, wraddr, wrdata, start, key,
    input  busy, done, hit, index
  );

  modport slave (
    input  wren, wraddr, wrdata, start, key,
    output busy, done, hit, index
  );
endinterface

// File: rtl/lut_index_finder.sv
// Sequential reverse lookup: scans a writable DEPTH-entry table one entry per cycle
// for the lowest index holding key. Define LUT_FIND_PRELOAD_EN to reset-load the tap patterns.
module lut_index_finder #(
  parameter int AW    = 5,
  parameter int DW    = 10,
  parameter int DEPTH = 2**AW
) (
  input  logic              clk,
  input  logic              reset,
  lut_index_finder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    ptr_reg, ptr_next;
  logic [AW-1:0]    index_reg, index_next;
  logic [DW-1:0]    keyq_reg, keyq_next;
  logic             hit_reg, hit_next;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_init;
  logic             wr_ok;
  logic             match;

`ifdef LUT_FIND_PRELOAD_EN
  localparam int PRELOAD_N = 9;
  localparam logic [9:0] TAPS [PRELOAD_N] = '{
    10'h060, 10'h048, 10'h078, 10'h072, 10'h06A,
    10'h069, 10'h05C, 10'h07E, 10'h07B
  };
  logic [DW-1:0] init_data [DEPTH];
`else
  localparam int PRELOAD_N = 0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_init
      assign valid_init[gi] = (gi < PRELOAD_N);
`ifdef LUT_FIND_PRELOAD_EN
      if (gi < PRELOAD_N) begin : g_tap
        assign init_data[gi] = DW'(TAPS[gi]);
      end else begin : g_blank
        assign init_data[gi] = '0;
      end
`endif
    end
  endgenerate

  // Writes are frozen during a scan so the table is stable while it is walked.
  assign wr_ok = bus.wren && (state_reg != SEARCH);
  assign match = valid_reg[ptr_reg] && (mem[ptr_reg] == keyq_reg);

`ifdef LUT_FIND_PRELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_data[i];
    end else if (wr_ok) begin
      mem[bus.wraddr] <= bus.wrdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wraddr] <= bus.wrdata;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= valid_init;
    end else if (wr_ok) begin
      valid_reg[bus.wraddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      keyq_reg  <= '0;
      hit_reg   <= 1'b0;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      keyq_reg  <= keyq_next;
      hit_reg   <= hit_next;
      index_reg <= index_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    keyq_next  = keyq_reg;
    hit_next   = hit_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          keyq_next  = bus.key;
          ptr_next   = '0;
          hit_next   = 1'b0;
          index_next = '0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (match) begin
          hit_next   = 1'b1;
          index_next = ptr_reg;
          state_next = DONE;
        end else if (ptr_reg == LAST_PTR) begin
          hit_next   = 1'b0;
          index_next = '0;
          state_next = DONE;
        end else begin
          ptr_next = ptr_reg + AW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  always_comb begin
    bus.busy  = (state_reg == SEARCH);
    bus.done  = (state_reg == DONE);
    bus.hit   = hit_reg;
    bus.index = index_reg;
  end

endmodule

// File: tb/tb_lut_index_finder.sv
// Directed plus randomized bench for lut_index_finder, checked against a
// first-match-in-array reference model with spec-derived cycle counts.
module tb_lut_index_finder;

  localparam int AW    = 5;
  localparam int DW    = 10;
  localparam int DEPTH = 32;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [DW-1:0] m_data  [DEPTH];
  bit            m_valid [DEPTH];

  lut_index_finder_if #(.AW(AW), .DW(DW)) bus ();

  lut_index_finder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
`ifdef LUT_FIND_PRELOAD_EN
    m_data[0] = 10'h060; m_data[1] = 10'h048; m_data[2] = 10'h078;
    m_data[3] = 10'h072; m_data[4] = 10'h06A; m_data[5] = 10'h069;
    m_data[6] = 10'h05C; m_data[7] = 10'h07E; m_data[8] = 10'h07B;
    for (int i = 0; i < 9; i++) m_valid[i] = 1'b1;
`endif
  endtask

  // Lowest valid index holding k; done arrives two cycles after the hit entry, or at DEPTH+1.
  task automatic ref_lookup(input logic [DW-1:0] k, output bit h, output int idx, output int dcyc);
    h = 1'b0;
    idx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && m_data[i] == k) begin
        h = 1'b1;
        idx = i;
      end
    end
    dcyc = h ? idx + 2 : DEPTH + 1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wren = 1'b1; bus.wraddr = a; bus.wrdata = d;
    m_data[a] = d; m_valid[a] = 1'b1;
    @(negedge clk);
    bus.wren = 1'b0;
  endtask

  task automatic search(input logic [DW-1:0] k, input bit disturb, input bit with_wr,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input string tag);
    bit exp_hit;
    int exp_idx, exp_done, cyc, bad_busy;
    if (with_wr) begin
      m_data[wa] = wd;
      m_valid[wa] = 1'b1;
    end
    ref_lookup(k, exp_hit, exp_idx, exp_done);
    @(negedge clk);
    bus.start = 1'b1; bus.key = k;
    if (with_wr) begin
      bus.wren = 1'b1; bus.wraddr = wa; bus.wrdata = wd;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.wren = 1'b0; bus.key = DW'($urandom);
    cyc = 1;
    bad_busy = 0;
    while (bus.done !== 1'b1 && cyc <= DEPTH + 4) begin
      if (bus.busy !== 1'b1) bad_busy++;
      if (disturb && cyc == 2) begin
        bus.wren = 1'b1; bus.wraddr = 5'd7; bus.wrdata = 10'h3FF;
        bus.start = 1'b1; bus.key = 10'h3FF;
      end else begin
        bus.wren = 1'b0; bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.wren = 1'b0; bus.start = 1'b0;
    chk({tag, "_busy_gaps"}, bad_busy, 0);
    chk({tag, "_done_cycle"}, cyc, exp_done);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b0);
    chk({tag, "_hit"}, bus.hit, exp_hit);
    chk({tag, "_index"}, bus.index, exp_idx);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    chk({tag, "_index_hold"}, bus.index, exp_idx);
    $display("search %s key=%03h hit=%0b index=%0d done_cycle=%0d", tag, k, bus.hit, bus.index, cyc);
  endtask

  initial begin
    bit exp_hit;
    int exp_idx, exp_done, cyc, n_done, dones_seen;
    int done_at [3];
    logic [DW-1:0] k;

    vectors = 0;
    miscompares = 0;
    bus.wren = 1'b0; bus.wraddr = '0; bus.wrdata = '0;
    bus.start = 1'b0; bus.key = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hit", bus.hit, 1'b0);
    chk("rst_index", bus.index, '0);
    reset = 1'b1;

    do_write(5'd12, 10'h040);
    search(10'h040, 1'b0, 1'b0, '0, '0, "e12_hit");
    search(10'h041, 1'b0, 1'b0, '0, '0, "e12_miss");

    do_write(5'd20, 10'h020);
    do_write(5'd7, 10'h020);
    search(10'h020, 1'b1, 1'b0, '0, '0, "dup_drop_wr");
    search(10'h020, 1'b0, 1'b0, '0, '0, "dup_recheck");
    search(10'h3FF, 1'b0, 1'b0, '0, '0, "dropped_val");

    search(10'h155, 1'b0, 1'b1, 5'd0, 10'h155, "same_cycle_wr");

    for (int t = 0; t < 16; t++) begin
      do_write(AW'($urandom_range(0, DEPTH - 1)), DW'(10'h100 + $urandom_range(0, 7)));
      search(DW'(10'h100 + $urandom_range(0, 8)), 1'b0, 1'b0, '0, '0, $sformatf("rnd%0d", t));
    end

    // Reset in cycle 10 of a miss search.
    k = 10'h2A5;
    @(negedge clk);
    bus.start = 1'b1; bus.key = k;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_hit", bus.hit, 1'b0);
    chk("abort_index", bus.index, '0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    dones_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones_seen++;
    end
    chk("abort_no_done", dones_seen, 0);
    search(10'h07B, 1'b0, 1'b0, '0, '0, "post_rst_07b");
    search(10'h040, 1'b0, 1'b0, '0, '0, "post_rst_040");

    // Start held high: each new search is accepted the cycle after done.
    do_write(5'd2, 10'h0AA);
    ref_lookup(10'h0AA, exp_hit, exp_idx, exp_done);
    @(negedge clk);
    bus.start = 1'b1; bus.key = 10'h0AA;
    cyc = 0;
    n_done = 0;
    while (n_done < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        done_at[n_done] = cyc;
        chk($sformatf("b2b%0d_index", n_done), bus.index, exp_idx);
        n_done++;
        if (n_done == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", n_done, 3);
    if (n_done == 3) begin
      chk("b2b_done0", done_at[0], exp_done);
      chk("b2b_done1", done_at[1], 2 * exp_done + 1);
      chk("b2b_done2", done_at[2], 3 * exp_done + 2);
    end
    $display("back_to_back key=0aa dones=%0d first=%0d", n_done, done_at[0]);
    repeat (3) @(negedge clk);
    chk("b2b_idle_after", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
